// File: rtl/multi_pulse_pkg.sv
// multi_pulse_pkg
//   Shared definitions for the multi-pulse gate-drive generator:
//   - state_t        : sequencer states (also exported on state_dbg)
//   - DRIVE_ON/OFF   : gate-enable level driven in each phase
//   - phase_drive()  : maps a state to the gate-enable level
//   - cfg_valid()    : decides whether a trigger may start a sequence
package multi_pulse_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int NUM_W_DEF  = 4;
    localparam int HOLD_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FIRST_HIGH = 3'd1,
        ST_LOW        = 3'd2,
        ST_HIGH       = 3'd3,
        ST_HOLDOFF    = 3'd4
    } state_t;

    localparam logic DRIVE_ON  = 1'b1;
    localparam logic DRIVE_OFF = 1'b0;

    // Only the two high phases enable the gate driver.
    function automatic logic phase_drive(input state_t s);
        case (s)
            ST_FIRST_HIGH, ST_HIGH: return DRIVE_ON;
            default:                return DRIVE_OFF;
        endcase
    endfunction

    // A single pulse needs only a non-zero first width; trains of two or
    // more also need non-zero gap and repeat widths.
    function automatic logic cfg_valid(input logic num_zero,
                                       input logic num_multi,
                                       input logic first_zero,
                                       input logic high_zero,
                                       input logic low_zero);
        return !num_zero && !first_zero && !(num_multi && (high_zero || low_zero));
    endfunction

endpackage

// File: rtl/multi_pulse_gen_trig_sync.sv
// trig_sync
//   Brings the asynchronous trigger into the clk domain through two flops
//   and flags its rising edge.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (all flops clear to 0)
//   trig  in  asynchronous trigger
//   rise  out high for one cycle after the synchronised trigger goes 0->1
module trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1   <= trig;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    // Both terms are flop outputs, so the edge flag is glitch-free and is
    // seen by the sequencer one edge after sync2 rises.
    assign rise = sync2 & ~sync2_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen
//   On a trigger rising edge emits a train of cfg_num_pulses high pulses
//   (first pulse cfg_first_high wide, then cfg_low gap / cfg_high pulse
//   pairs), followed by a cfg_holdoff lockout before re-arming.
//   clk, rst_n        clock, asynchronous active-low reset
//   trig              asynchronous start request (rising edge)
//   abort             synchronous stop of an active pulse train
//   cfg_*             widths / count / hold-off, latched on an accepted edge
//   pulse_out         registered gate enable
//   busy              high from the first pulse through the end of hold-off
//   done / aborted    one-cycle end-of-train strobes
//   cfg_err           one-cycle strobe, trigger rejected for bad config
//   pulse_idx         1-based index of the current / last high pulse
//   state_dbg         current sequencer state (state_t encoding)
//
//   Handshake: there is no valid/ready pairing; trig is a level whose
//   rising edge is a request, honoured only in IDLE, and done / aborted /
//   cfg_err are single-cycle completion strobes that need no acknowledge.
module multi_pulse_gen
    import multi_pulse_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NUM_W  = NUM_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_first_high,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    input  logic [NUM_W-1:0]  cfg_num_pulses,
    input  logic [HOLD_W-1:0] cfg_holdoff,
    output logic              pulse_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              cfg_err,
    output logic [NUM_W-1:0]  pulse_idx,
    output logic [2:0]        state_dbg
);

    state_t              state;
    state_t              state_next;
    logic                trig_rise;
    logic                cfg_ok;

    logic [CNT_W-1:0]    high_q;
    logic [CNT_W-1:0]    low_q;
    logic [NUM_W-1:0]    num_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [CNT_W-1:0]    phase_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                accept;
    logic                phase_load;
    logic [CNT_W-1:0]    phase_val;
    logic                hold_load;
    logic                idx_first;
    logic                idx_inc;
    logic                done_n;
    logic                aborted_n;
    logic                cfg_err_n;

    trig_sync u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (trig),
        .rise  (trig_rise)
    );

    assign cfg_ok = cfg_valid(cfg_num_pulses == '0,
                              cfg_num_pulses > NUM_W'(1),
                              cfg_first_high == '0,
                              cfg_high == '0,
                              cfg_low == '0);

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        phase_load = 1'b0;
        phase_val  = '0;
        hold_load  = 1'b0;
        idx_first  = 1'b0;
        idx_inc    = 1'b0;
        done_n     = 1'b0;
        aborted_n  = 1'b0;
        cfg_err_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_rise) begin
                    if (cfg_ok) begin
                        accept     = 1'b1;
                        state_next = ST_FIRST_HIGH;
                        phase_load = 1'b1;
                        phase_val  = cfg_first_high - CNT_W'(1);
                        idx_first  = 1'b1;
                    end else begin
                        cfg_err_n = 1'b1;
                    end
                end
            end
            ST_FIRST_HIGH, ST_LOW, ST_HIGH: begin
                // abort outranks a phase ending in the same cycle
                if (abort) begin
                    aborted_n = 1'b1;
                end else if (phase_cnt == '0) begin
                    if (state == ST_LOW) begin
                        state_next = ST_HIGH;
                        phase_load = 1'b1;
                        phase_val  = high_q - CNT_W'(1);
                        idx_inc    = 1'b1;
                    end else if (pulse_idx == num_q) begin
                        done_n = 1'b1;
                    end else begin
                        state_next = ST_LOW;
                        phase_load = 1'b1;
                        phase_val  = low_q - CNT_W'(1);
                    end
                end
                if (done_n || aborted_n) begin
                    if (hold_q == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_HOLDOFF;
                        hold_load  = 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == '0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q    <= '0;
            low_q     <= '0;
            num_q     <= '0;
            hold_q    <= '0;
            phase_cnt <= '0;
            hold_cnt  <= '0;
            pulse_idx <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (accept) begin
                high_q <= cfg_high;
                low_q  <= cfg_low;
                num_q  <= cfg_num_pulses;
                hold_q <= cfg_holdoff;
            end
            // counters load width-1 and stop at zero
            if (phase_load)            phase_cnt <= phase_val;
            else if (phase_cnt != '0)  phase_cnt <= phase_cnt - CNT_W'(1);
            if (hold_load)             hold_cnt  <= hold_q - HOLD_W'(1);
            else if (hold_cnt != '0)   hold_cnt  <= hold_cnt - HOLD_W'(1);
            if (idx_first)             pulse_idx <= NUM_W'(1);
            else if (idx_inc)          pulse_idx <= pulse_idx + NUM_W'(1);
            pulse_out <= phase_drive(state_next);
            // the end-of-train strobe cycle still counts as busy, even when
            // a zero hold-off returns straight to IDLE
            busy      <= (state_next != ST_IDLE) || done_n || aborted_n;
            done      <= done_n;
            aborted   <= aborted_n;
            cfg_err   <= cfg_err_n;
        end
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen
//   Drives directed and random pulse-train requests into multi_pulse_gen.
//   The driver turns each request into the list of events the train should
//   produce (start latency, every high/low run length with its index, end
//   strobe, hold-off length); the monitor measures the same events from
//   the DUT pins and compares them in order.
`timescale 1ns/1ps
module tb_multi_pulse_gen;

    localparam int CNT_W  = 16;
    localparam int NUM_W  = 4;
    localparam int HOLD_W = 24;

    localparam logic [3:0] K_LAT   = 4'd1;
    localparam logic [3:0] K_HIGH  = 4'd2;
    localparam logic [3:0] K_LOW   = 4'd3;
    localparam logic [3:0] K_DONE  = 4'd4;
    localparam logic [3:0] K_ABORT = 4'd5;
    localparam logic [3:0] K_HOLD  = 4'd6;
    localparam logic [3:0] K_ERR   = 4'd7;
    localparam logic [3:0] K_STRAY = 4'd8;

    logic              clk;
    logic              rst_n;
    logic              trig;
    logic              abort;
    logic [CNT_W-1:0]  cfg_first_high;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_low;
    logic [NUM_W-1:0]  cfg_num_pulses;
    logic [HOLD_W-1:0] cfg_holdoff;
    logic              pulse_out;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              cfg_err;
    logic [NUM_W-1:0]  pulse_idx;
    logic [2:0]        state_dbg;

    logic [39:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    multi_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W), .HOLD_W(HOLD_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trig           (trig),
        .abort          (abort),
        .cfg_first_high (cfg_first_high),
        .cfg_high       (cfg_high),
        .cfg_low        (cfg_low),
        .cfg_num_pulses (cfg_num_pulses),
        .cfg_holdoff    (cfg_holdoff),
        .pulse_out      (pulse_out),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .cfg_err        (cfg_err),
        .pulse_idx      (pulse_idx),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [39:0] mk(input logic [3:0] k, input int idx, input int val);
        return {k, 4'(idx), 32'(val)};
    endfunction

    function automatic string kname(input logic [3:0] k);
        case (k)
            K_LAT:   return "start_latency";
            K_HIGH:  return "high_run";
            K_LOW:   return "low_run";
            K_DONE:  return "done_strobe";
            K_ABORT: return "aborted_strobe";
            K_HOLD:  return "holdoff_len";
            K_ERR:   return "cfg_err_latency";
            K_STRAY: return "pulse_outside_busy";
            default: return "unknown";
        endcase
    endfunction

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic observe(input logic [39:0] got);
        logic [39:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got idx=%0d val=%0d, required no event", kname(got[39:36]),
                     got[35:32], got[31:0]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %s idx=%0d val=%0d, required %s idx=%0d val=%0d",
                         kname(e[39:36]), kname(got[39:36]), got[35:32], got[31:0],
                         kname(e[39:36]), e[35:32], e[31:0]);
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int   cyc;
        int   trig_cyc;
        int   hi_len;
        int   lo_len;
        int   hold_len;
        logic prev_pulse;
        logic prev_busy;
        logic prev_trig;
        logic lo_active;
        logic hold_active;
        logic [3:0] last_idx;
        cyc = 0; trig_cyc = 0; hi_len = 0; lo_len = 0; hold_len = 0;
        prev_pulse = 0; prev_busy = 0; prev_trig = 0; lo_active = 0; hold_active = 0;
        last_idx = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                hi_len = 0; lo_len = 0; hold_len = 0;
                prev_pulse = 0; prev_busy = 0; lo_active = 0; hold_active = 0;
                prev_trig = trig;
                continue;
            end
            if (trig && !prev_trig && !busy) trig_cyc = cyc;
            prev_trig = trig;
            if (busy && !prev_busy) observe(mk(K_LAT, 0, cyc - trig_cyc));
            if (cfg_err) observe(mk(K_ERR, 0, cyc - trig_cyc));
            if (pulse_out && !busy) observe(mk(K_STRAY, 0, 0));
            if (pulse_out) begin
                if (!prev_pulse && lo_active) observe(mk(K_LOW, 0, lo_len));
                lo_active = 0;
                hi_len++;
                last_idx = pulse_idx;
            end else begin
                if (prev_pulse) begin
                    observe(mk(K_HIGH, int'(last_idx), hi_len));
                    hi_len = 0;
                    lo_active = 1;
                    lo_len = 0;
                end
                if (lo_active) lo_len++;
            end
            if (done) begin
                observe(mk(K_DONE, int'(pulse_idx), 0));
                lo_active = 0; hold_active = 1; hold_len = 0;
            end
            if (aborted) begin
                observe(mk(K_ABORT, int'(pulse_idx), 0));
                lo_active = 0; hold_active = 1; hold_len = 0;
            end
            if (hold_active) begin
                if (busy) hold_len++;
                else begin
                    observe(mk(K_HOLD, 0, hold_len));
                    hold_active = 0;
                end
            end
            prev_pulse = pulse_out;
            prev_busy  = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_val("busy_release_timeout", int'(busy), 0);
        repeat (4) @(negedge clk);
    endtask

    // abort_t: sequence cycle (0 = first high cycle) during which abort is
    // held, or -1. retog re-triggers mid-train and mid-hold-off, scrambles
    // the cfg inputs and pulses abort inside the hold-off.
    task automatic run_seq(input int fh, input int lo, input int hi, input int n,
                           input int ho, input int abort_t, input bit retog);
        int  pos;
        int  end_t;
        int  total;
        int  rt1;
        int  rt2;
        int  w;
        bit  stop;
        cfg_first_high = 16'(fh);
        cfg_low        = 16'(lo);
        cfg_high       = 16'(hi);
        cfg_num_pulses = 4'(n);
        cfg_holdoff    = 24'(ho);
        exp_q.push_back(mk(K_LAT, 0, 2));
        pos = 0;
        stop = 0;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) begin
                if (abort_t >= 0 && abort_t < pos + lo) begin
                    exp_q.push_back(mk(K_ABORT, i - 1, 0));
                    stop = 1;
                    break;
                end
                exp_q.push_back(mk(K_LOW, 0, lo));
                pos += lo;
            end
            w = (i == 1) ? fh : hi;
            if (abort_t >= 0 && abort_t < pos + w) begin
                exp_q.push_back(mk(K_HIGH, i, abort_t - pos + 1));
                exp_q.push_back(mk(K_ABORT, i, 0));
                stop = 1;
                break;
            end
            exp_q.push_back(mk(K_HIGH, i, w));
            pos += w;
        end
        if (!stop) exp_q.push_back(mk(K_DONE, n, 0));
        exp_q.push_back(mk(K_HOLD, 0, (ho > 0) ? ho : 1));

        end_t = (abort_t >= 0) ? abort_t + 1 : fh + (n - 1) * (lo + hi);
        total = 3 + end_t + ((ho > 0) ? ho : 1) + 3;
        rt1 = 1;
        rt2 = end_t + ho / 2;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            trig  = (c < 3) ||
                    (retog && ((c >= 3 + rt1 && c < 6 + rt1) || (c >= 3 + rt2 && c < 6 + rt2)));
            abort = (abort_t >= 0 && c == 3 + abort_t) || (retog && c == 4 + rt2);
            if (retog && c == 3 + rt1) begin
                cfg_first_high = 16'($urandom_range(1, 40));
                cfg_low        = 16'($urandom_range(1, 40));
                cfg_high       = 16'($urandom_range(1, 40));
                cfg_num_pulses = 4'($urandom_range(1, 15));
                cfg_holdoff    = 24'($urandom_range(0, 40));
            end
        end
        trig  = 0;
        abort = 0;
        wait_idle();
    endtask

    task automatic run_bad(input int fh, input int lo, input int hi, input int n);
        cfg_first_high = 16'(fh);
        cfg_low        = 16'(lo);
        cfg_high       = 16'(hi);
        cfg_num_pulses = 4'(n);
        cfg_holdoff    = 24'd4;
        exp_q.push_back(mk(K_ERR, 0, 2));
        trig = 1;
        repeat (3) @(negedge clk);
        trig = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_reset(input bit mid_high);
        int t;
        cfg_first_high = 16'd6;
        cfg_low        = 16'd10;
        cfg_high       = 16'd8;
        cfg_num_pulses = 4'd3;
        cfg_holdoff    = 24'd5;
        t = mid_high ? 19 : 10;
        exp_q.push_back(mk(K_LAT, 0, 2));
        exp_q.push_back(mk(K_HIGH, 1, 6));
        if (mid_high) exp_q.push_back(mk(K_LOW, 0, 10));
        for (int c = 0; c <= 3 + t; c++) begin
            @(negedge clk);
            trig = (c < 3);
        end
        check_val(mid_high ? "pre_reset_pulse_high" : "pre_reset_pulse_low",
                  int'(pulse_out), mid_high ? 1 : 0);
        #2 rst_n = 0;
        #1;
        check_val("async_reset_pulse_out", int'(pulse_out), 0);
        check_val("async_reset_busy", int'(busy), 0);
        check_val("async_reset_pulse_idx", int'(pulse_idx), 0);
        check_val("async_reset_state", int'(state_dbg), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0;
        trig = 0;
        abort = 0;
        cfg_first_high = '0;
        cfg_high = '0;
        cfg_low = '0;
        cfg_num_pulses = '0;
        cfg_holdoff = '0;
        repeat (3) @(negedge clk);
        check_val("reset_pulse_out", int'(pulse_out), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_done", int'(done), 0);
        check_val("reset_aborted", int'(aborted), 0);
        check_val("reset_cfg_err", int'(cfg_err), 0);
        check_val("reset_pulse_idx", int'(pulse_idx), 0);
        check_val("reset_state", int'(state_dbg), 0);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // abort while idle must do nothing
        abort = 1;
        @(negedge clk);
        abort = 0;
        repeat (3) @(negedge clk);

        run_seq(800, 520, 800, 2, 100, -1, 0);
        run_seq(3, 2, 4, 5, 0, -1, 0);

        run_bad(5, 3, 3, 0);
        run_bad(5, 0, 3, 3);
        run_bad(0, 3, 3, 1);
        run_bad(5, 3, 0, 2);
        run_seq(4, 0, 0, 1, 3, -1, 0);

        run_seq(12, 6, 15, 3, 20, 12 + 6 + 9, 0);
        run_seq(20, 10, 15, 3, 30, -1, 1);

        run_reset(0);
        run_reset(1);
        run_seq(5, 4, 6, 3, 7, -1, 0);

        for (int r = 0; r < 25; r++) begin
            int fh;
            int lo;
            int hi;
            int n;
            int ho;
            int sl;
            int at;
            fh = int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 8));
            hi = int'($urandom_range(1, 8));
            n  = int'($urandom_range(1, 6));
            ho = int'($urandom_range(0, 15));
            sl = fh + (n - 1) * (lo + hi);
            at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sl - 1)) : -1;
            run_seq(fh, lo, hi, n, ho, at, 0);
        end

        run_seq(65535, 1, 1, 1, 2, -1, 0);

        repeat (5) @(negedge clk);
        check_val("unmatched_expected_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_pulse_gen.md
# multi_pulse_gen

Parametrised multi-pulse gate-drive test generator, successor to the fixed double-pulse block used for switching-device characterisation. On a rising edge of an asynchronous trigger it emits a programmable train of N high pulses: a first (charging) pulse, then repeated low/high pairs, with all widths in clock cycles. The block enforces a mandatory hold-off after every sequence, normal or aborted, so the device under test can cool down. It drives the gate-driver enable (K1-style output) in the test fixture.

## Interface
- CNT_W, 16: width of every phase-duration counter and config field.
- NUM_W, 4: width of pulse-count config; up to 2^NUM_W-1 pulses.
- HOLD_W, 24: width of hold-off counter/config.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- trig  in  1  start request, asynchronous to clk; rising edge starts a sequence.
- abort  in  1  synchronous level; terminates an active sequence.
- cfg_first_high  in  CNT_W  first pulse high width, cycles.
- cfg_high  in  CNT_W  width of each subsequent high pulse, cycles.
- cfg_low  in  CNT_W  width of each low gap, cycles.
- cfg_num_pulses  in  NUM_W  total high pulses; 2 = classic double pulse.
- cfg_holdoff  in  HOLD_W  re-arm lockout after sequence end, cycles.
- pulse_out  out  1  gate enable, registered.
- busy  out  1  high from first high phase through end of hold-off.
- done  out  1  one-cycle strobe, normal sequence completion.
- aborted  out  1  one-cycle strobe, sequence ended by abort.
- cfg_err  out  1  one-cycle strobe, trigger rejected for bad config.
- pulse_idx  out  NUM_W  1-based index of current/last high pulse; 0 in IDLE after reset.

## Operation
- States: IDLE, FIRST_HIGH, LOW, HIGH, HOLDOFF.
- trig passes a 2-FF synchroniser, then rising-edge detect. Only edges seen in IDLE count; edges during busy are dropped, not queued.
- On accepted edge, all cfg_* inputs are latched. Later cfg changes have no effect until the next accepted edge.
- Config is rejected when cfg_num_pulses=0, cfg_first_high=0, or, when cfg_num_pulses>1, cfg_high=0 or cfg_low=0. On rejection: cfg_err strobe, stay IDLE, pulse_out stays 0.
- FIRST_HIGH lasts cfg_first_high cycles with pulse_out=1, pulse_idx=1.
- If pulses remain: LOW for cfg_low cycles with pulse_out=0, then HIGH for cfg_high cycles with pulse_out=1 and pulse_idx incremented. Repeat until pulse_idx=cfg_num_pulses.
- After the last high phase: done strobe, then HOLDOFF for cfg_holdoff cycles. With cfg_holdoff=0, go directly to IDLE.
- abort high in FIRST_HIGH/LOW/HIGH: pulse_out=0 at next edge, aborted strobe, enter HOLDOFF with full latched hold-off; no done. abort in IDLE/HOLDOFF is ignored.
- Phase counters load width-1 and count down to 0; no wrap; a width of 2^CNT_W-1 is legal.
- Reset values: pulse_out=0, busy=0, done=0, aborted=0, cfg_err=0, pulse_idx=0, state IDLE, synchroniser flops 0. Reset mid-sequence drops pulse_out immediately (asynchronously).

## Timing
- Edge k is the first clk edge sampling trig high. FSM leaves IDLE and pulse_out rises at edge k+2. cfg_err, if applicable, is also asserted at k+2.
- pulse_out high exactly cfg_first_high cycles, low exactly cfg_low, high exactly cfg_high. Phases are contiguous, with no idle cycle between them.
- done is asserted in the first cycle pulse_out is 0 after the last pulse, and busy is still 1 in that cycle.
- busy falls after cfg_holdoff cycles of HOLDOFF. The next trig edge is accepted once IDLE is re-entered; if synchronised trig is already high, a new rising edge is needed.
- abort latency: one cycle to pulse_out=0, with aborted asserted the same cycle.

## Structure
- Package multi_pulse_pkg: state enum, phase-to-output mapping constants, config-valid check function.
- Sub-module trig_sync: 2-FF synchroniser plus registered rising-edge detect, async active-low reset.
- Top module holds FSM, phase counter, pulse index counter and hold-off counter.

## Test plan
- Double pulse: first_high=800, low=520, high=800, num=2, holdoff=100. Check pulse_out shows 800H/520L/800H, done once, busy falls 100 cycles after done.
- Five pulses, widths 3/2/4, holdoff=0. Check pulse_idx 1..5, exactly 5 rising edges on pulse_out, IDLE immediately after done.
- cfg_num_pulses=0, then cfg_low=0 with num=3. Check a cfg_err strobe for each case, pulse_out never 1, busy never 1.
- abort asserted in cycle 10 of the 2nd HIGH. Check pulse_out=0 next cycle, aborted strobe, no done, full hold-off then IDLE.
- trig re-toggled during a sequence and during HOLDOFF, with cfg changed mid-run. Check no extra pulses and latched widths unchanged.
- rst_n asserted mid-LOW and mid-HIGH. Check all outputs 0 immediately and a fresh sequence runs correctly after release.
